// File: rtl/credbasedfc_pkg.sv
// Shared credit-based flow-control constants, used by both sender and receiver.
// Defaults here set the payload width, buffer depth and sender credit-counter width.
package credbasedfc_pkg;

    localparam int CBFC_D_WIDTH      = 6;
    localparam int CBFC_DEPTH        = 4;
    localparam int CBFC_CREDIT_WIDTH = 3;
    localparam int CBFC_LVL_WIDTH    = $clog2(CBFC_DEPTH + 1);

    // Pointer width carries one wrap bit above the index so full and empty can be told apart
    function automatic int cbfc_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/credbasedfc_rx_fifo.sv
// Receiver circular buffer: storage, wrap-bit pointers, full/empty and registered fill level.
// Latency: first-word-fall-through, a beat pushed at edge N is at the head in cycle N+1.
// Backpressure: none on the push side; a push while full with no pop is dropped and flagged.
module credbasedfc_rx_fifo
    import credbasedfc_pkg::*;
#(
    parameter int D_WIDTH   = CBFC_D_WIDTH,
    parameter int DEPTH     = CBFC_DEPTH,
    parameter int LVL_WIDTH = CBFC_LVL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push_vld,
    input  logic [D_WIDTH-1:0]   i_push_dat,
    output logic [D_WIDTH-1:0]   o_pop_dat,
    output logic                 o_pop_vld,
    input  logic                 i_pop_rdy,
    output logic                 o_pop,
    output logic                 o_drop,
    output logic [LVL_WIDTH-1:0] o_fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = cbfc_ptr_width(DEPTH);

    logic [D_WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [LVL_WIDTH-1:0] r_fill;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Pop is gated by the registered empty flag, so a push into an empty buffer never pops
    assign w_pop  = !w_empty && i_pop_rdy;
    assign w_push = i_push_vld && (!w_full || w_pop);
    assign o_drop = i_push_vld && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_fill <= r_fill + LVL_WIDTH'(1);
            else if (w_pop && !w_push) r_fill <= r_fill - LVL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
    end

    assign o_pop_dat    = r_mem[r_rptr[AW-1:0]];
    assign o_pop_vld    = !w_empty;
    assign o_pop        = w_pop;
    assign o_fill_level = r_fill;

endmodule

// File: rtl/credbasedfc_rx_44.sv
// Credit-based flow-control receiver: buffers sender beats, returns one credit pulse per pop.
// Latency: push to head 1 cycle, pop to credit 1 cycle; no backpressure to sender (credits only).
// Sticky overflow detection is built only when CREDBASEDFC_RX_OVF_CHECK_EN is defined.
module credbasedfc_rx_44
    import credbasedfc_pkg::*;
#(
    parameter int D_WIDTH   = CBFC_D_WIDTH,
    parameter int DEPTH     = CBFC_DEPTH,
    parameter int LVL_WIDTH = CBFC_LVL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 out_credit,
    output logic [D_WIDTH-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LVL_WIDTH-1:0] fill_level,
    output logic                 overflow
);

    logic w_pop;
    logic w_drop;
    logic r_credit;

    credbasedfc_rx_fifo #(
        .D_WIDTH   (D_WIDTH),
        .DEPTH     (DEPTH),
        .LVL_WIDTH (LVL_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_vld   (in_valid),
        .i_push_dat   (in_data),
        .o_pop_dat    (out_data),
        .o_pop_vld    (out_valid),
        .i_pop_rdy    (out_ready),
        .o_pop        (w_pop),
        .o_drop       (w_drop),
        .o_fill_level (fill_level)
    );

    // One credit per popped beat, never coalesced: at most one pop per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_credit <= 1'b0;
        else        r_credit <= w_pop;
    end

    assign out_credit = r_credit;

`ifdef CREDBASEDFC_RX_OVF_CHECK_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`else
    logic w_unused_drop;

    assign w_unused_drop = w_drop;
    assign overflow      = 1'b0;
`endif

endmodule
